// File: rtl/reg_bank_slave_if.sv
// reg_bank_slave_if: request/response bus between a host initiator and the
// register bank responder.
//
// Handshake (both channels): a beat transfers on a rising clk edge where
// valid and ready are both 1. Once the slave raises rsp_valid, it holds
// rsp_valid, rsp_rdata and rsp_err stable until the host's rsp_ready
// completes the beat. The host may drop req_valid at any time before the
// request transfers.
//
// Signals:
//   req_valid / req_ready   request channel handshake
//   req_wr                  1 = write, 0 = read
//   req_addr  [ADDR_W]      register index
//   req_wdata [DATA_W]      write data
//   req_be    [DATA_W/8]    byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid / rsp_ready   response channel handshake
//   rsp_rdata [DATA_W]      read data (0 for writes and errors)
//   rsp_err                 address out of range
interface reg_bank_slave_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/reg_bank_slave.sv
// reg_bank_slave: bus-side responder for a bank of byte-enable-written
// configuration registers. One request is accepted in IDLE, its response is
// presented in RESP until the host takes it, giving at most one request per
// two cycles.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   bus        reg_bank_slave_if slave modport (request + response channels)
//   reg_out    flattened register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse   one-cycle strobe per register written (first RESP cycle)
//   dbg_state  current FSM state (0 = IDLE, 1 = RESP)
module reg_bank_slave #(
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    reg_bank_slave_if.slave            bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        wr_pulse,
    output logic                       dbg_state
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic                accept;
    logic                in_range;
    logic                wr_hit;
    logic [DATA_W-1:0]   rd_val;

    // req_ready is the only output not taken from a flop; it is gated by
    // rst_n so it reads 0 for the whole time reset is asserted.
    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign accept        = bus.req_valid && (state_q == IDLE);
    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    assign in_range      = {1'b0, bus.req_addr} < (ADDR_W+1)'(NUM_REGS);
    assign wr_hit        = accept && bus.req_wr && in_range;

    // Read mux; out-of-range addresses fall through to 0.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.req_addr == ADDR_W'(k)) begin
                rd_val = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response registers: captured at the accept edge, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (!bus.req_wr && in_range) ? rd_val : '0;
            rsp_err_q   <= !in_range;
        end else if (state_q == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Strobe lives only in the cycle after the accept edge, so a stalled
    // response never repeats it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit && bus.req_addr == ADDR_W'(k)) begin
                    wr_pulse_q[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wr_hit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (bus.req_addr == ADDR_W'(k)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (bus.req_be[b]) begin
                            regs_q[k][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign wr_pulse      = wr_pulse_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_reg_bank_slave.sv
// tb_reg_bank_slave: directed test of reg_bank_slave. Inputs change on the
// falling edge; outputs are sampled on the falling edge before any change.
module tb_reg_bank_slave;
    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic [NUM_REGS-1:0]        wr_pulse;
    logic                       dbg_state;

    int checks = 0;
    int errors = 0;

    reg_bank_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_bank_slave #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first
    // RESP cycle.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic complete();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_req_ready", 192'(bus.req_ready), 192'(0));
        check("rst_rsp_valid", 192'(bus.rsp_valid), 192'(0));
        check("rst_reg_out", 192'(reg_out), 192'(0));
        check("rst_wr_pulse", 192'(wr_pulse), 192'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 192'(bus.req_ready), 192'(1));
        check("idle_state", 192'(dbg_state), 192'(0));

        // Read of reset register
        issue(1'b0, 3'd2, 32'h0, 4'h0);
        check("rd2_valid", 192'(bus.rsp_valid), 192'(1));
        check("rd2_rdata", 192'(bus.rsp_rdata), 192'(0));
        check("rd2_err", 192'(bus.rsp_err), 192'(0));
        check("rd2_req_ready", 192'(bus.req_ready), 192'(0));
        check("rd2_state", 192'(dbg_state), 192'(1));
        complete();
        check("rd2_done_ready", 192'(bus.req_ready), 192'(1));
        check("rd2_done_valid", 192'(bus.rsp_valid), 192'(0));

        // Full write to reg 1, held one extra cycle
        issue(1'b1, 3'd1, 32'hDEADBEEF, 4'hF);
        check("wr1_valid", 192'(bus.rsp_valid), 192'(1));
        check("wr1_rdata", 192'(bus.rsp_rdata), 192'(0));
        check("wr1_err", 192'(bus.rsp_err), 192'(0));
        check("wr1_pulse", 192'(wr_pulse), 192'(6'b000010));
        check("wr1_reg1", 192'(reg_out[63:32]), 192'(32'hDEADBEEF));
        @(negedge clk);
        check("wr1_pulse_once", 192'(wr_pulse), 192'(0));
        check("wr1_valid_held", 192'(bus.rsp_valid), 192'(1));
        complete();
        issue(1'b0, 3'd1, 32'h0, 4'h0);
        check("rd1_rdata", 192'(bus.rsp_rdata), 192'(32'hDEADBEEF));
        complete();

        // Byte enables on reg 3
        issue(1'b1, 3'd3, 32'h11223344, 4'hF);
        complete();
        issue(1'b1, 3'd3, 32'hAABBCCDD, 4'b0101);
        check("be_pulse", 192'(wr_pulse), 192'(6'b001000));
        check("be_reg3", 192'(reg_out[127:96]), 192'(32'h11BB33DD));
        complete();
        issue(1'b1, 3'd5, 32'h55555555, 4'h0);
        check("be0_pulse", 192'(wr_pulse), 192'(6'b100000));
        check("be0_reg5", 192'(reg_out[191:160]), 192'(0));
        complete();
        issue(1'b0, 3'd3, 32'h0, 4'h0);
        check("rd3_rdata", 192'(bus.rsp_rdata), 192'(32'h11BB33DD));
        complete();

        // Response stall with a competing write request
        issue(1'b0, 3'd1, 32'h0, 4'h0);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 3'd0;
        bus.req_wdata = 32'hFFFFFFFF;
        bus.req_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 192'(bus.rsp_valid), 192'(1));
            check("stall_rdata", 192'(bus.rsp_rdata), 192'(32'hDEADBEEF));
            check("stall_req_ready", 192'(bus.req_ready), 192'(0));
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("stall_reg0", 192'(reg_out[31:0]), 192'(0));
        check("stall_pulse", 192'(wr_pulse), 192'(0));
        complete();
        check("stall_done_ready", 192'(bus.req_ready), 192'(1));
        check("stall_done_state", 192'(dbg_state), 192'(0));

        // Out-of-range
        issue(1'b1, 3'd6, 32'hFFFFFFFF, 4'hF);
        check("oor6_err", 192'(bus.rsp_err), 192'(1));
        check("oor6_rdata", 192'(bus.rsp_rdata), 192'(0));
        check("oor6_pulse", 192'(wr_pulse), 192'(0));
        complete();
        issue(1'b1, 3'd7, 32'hFFFFFFFF, 4'hF);
        check("oor7_err", 192'(bus.rsp_err), 192'(1));
        check("oor7_pulse", 192'(wr_pulse), 192'(0));
        check("oor7_reg_out", 192'(reg_out),
              {32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'hDEADBEEF, 32'h0});
        complete();
        issue(1'b0, 3'd7, 32'h0, 4'h0);
        check("oor7_rd_err", 192'(bus.rsp_err), 192'(1));
        check("oor7_rd_rdata", 192'(bus.rsp_rdata), 192'(0));
        complete();

        // Async reset during RESP after a write to reg 4
        issue(1'b1, 3'd4, 32'h12345678, 4'hF);
        check("ar_valid_before", 192'(bus.rsp_valid), 192'(1));
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_drop", 192'(bus.rsp_valid), 192'(0));
        check("ar_reg_out", 192'(reg_out), 192'(0));
        check("ar_pulse", 192'(wr_pulse), 192'(0));
        check("ar_req_ready", 192'(bus.req_ready), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_release_ready", 192'(bus.req_ready), 192'(1));
        @(negedge clk);
        check("ar_post_pulse", 192'(wr_pulse), 192'(0));
        check("ar_post_valid", 192'(bus.rsp_valid), 192'(0));
        check("ar_post_ready", 192'(bus.req_ready), 192'(1));
        issue(1'b0, 3'd4, 32'h0, 4'h0);
        check("ar_rd4_rdata", 192'(bus.rsp_rdata), 192'(0));
        complete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
